// File: rtl/arb_req_conditioner.sv
// Per-channel request front end: 2-flop sync, debounce and request/grant/release FSM.
// Optional PEND timeout with DROP state enabled by `define ARB_REQ_COND_TIMEOUT_EN.
module arb_req_conditioner #(
  parameter int N        = 3,
  parameter int DEBOUNCE = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic [N-1:0] req_async_i,
  input  logic [N-1:0] gnt_i,
  output logic [N-1:0] req_o,
  output logic [N-1:0] timeout_o
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PEND = 2'd1;
  localparam logic [1:0] GNT  = 2'd2;
  localparam logic [1:0] DROP = 2'd3;

  if (DEBOUNCE < 1 || TIMEOUT < 2) begin : g_param_check
    $error("arb_req_conditioner: DEBOUNCE must be >= 1 and TIMEOUT >= 2");
  end

  logic [N-1:0]  s1, s2, deb, deb_nxt, req_nxt;
  logic [CW-1:0] cnt     [N];
  logic [CW-1:0] cnt_nxt [N];
  logic [1:0]    state     [N];
  logic [1:0]    state_nxt [N];

`ifdef ARB_REQ_COND_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] wait_cnt [N];
  logic [TW-1:0] wait_nxt [N];
  logic [N-1:0]  tmo_set;
`endif

  // Debouncer: accept a new level only after DEBOUNCE consecutive differing samples
  always_comb begin
    for (int i = 0; i < N; i++) begin
      deb_nxt[i] = deb[i];
      cnt_nxt[i] = {CW{1'b0}};
      if (s2[i] != deb[i]) begin
        if (cnt[i] == CNT_LAST) begin
          deb_nxt[i] = s2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end
      end else begin
        cnt_nxt[i] = {CW{1'b0}};
      end
    end
  end

  // Channel FSM next state; req_o is decoded from the next state so it is registered
  always_comb begin
    for (int i = 0; i < N; i++) begin
      state_nxt[i] = state[i];
`ifdef ARB_REQ_COND_TIMEOUT_EN
      wait_nxt[i] = {TW{1'b0}};
      tmo_set[i]  = 1'b0;
`endif
      case (state[i])
        IDLE: begin
          if (deb[i]) state_nxt[i] = PEND;
          else        state_nxt[i] = IDLE;
        end
        PEND: begin
          // A grant outranks both timeout and withdrawal in the same cycle
          if (gnt_i[i]) begin
            state_nxt[i] = GNT;
`ifdef ARB_REQ_COND_TIMEOUT_EN
          end else if (wait_cnt[i] == WAIT_LAST) begin
            state_nxt[i] = DROP;
            tmo_set[i]   = 1'b1;
`endif
          end else if (!deb[i]) begin
            state_nxt[i] = IDLE;
          end else begin
            state_nxt[i] = PEND;
`ifdef ARB_REQ_COND_TIMEOUT_EN
            wait_nxt[i]  = wait_cnt[i] + 1'b1;
`endif
          end
        end
        GNT: begin
          if (!deb[i]) state_nxt[i] = IDLE;
          else         state_nxt[i] = GNT;
        end
        DROP: begin
          if (!deb[i]) state_nxt[i] = IDLE;
          else         state_nxt[i] = DROP;
        end
        default: state_nxt[i] = IDLE;
      endcase
      req_nxt[i] = (state_nxt[i] == PEND) || (state_nxt[i] == GNT);
    end
  end

  // Synchronizer, debouncer, FSM and request output registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      s1    <= {N{1'b0}};
      s2    <= {N{1'b0}};
      deb   <= {N{1'b0}};
      req_o <= {N{1'b0}};
      for (int i = 0; i < N; i++) begin
        cnt[i]   <= {CW{1'b0}};
        state[i] <= IDLE;
      end
    end else begin
      s1    <= req_async_i;
      s2    <= s1;
      deb   <= deb_nxt;
      req_o <= req_nxt;
      for (int i = 0; i < N; i++) begin
        cnt[i]   <= cnt_nxt[i];
        state[i] <= state_nxt[i];
      end
    end
  end

`ifdef ARB_REQ_COND_TIMEOUT_EN
  // PEND wait counters and sticky timeout flags
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      timeout_o <= {N{1'b0}};
      for (int i = 0; i < N; i++) wait_cnt[i] <= {TW{1'b0}};
    end else begin
      timeout_o <= timeout_o | tmo_set;
      for (int i = 0; i < N; i++) wait_cnt[i] <= wait_nxt[i];
    end
  end
`else
  assign timeout_o = {N{1'b0}};
`endif

endmodule

// File: tb/tb_arb_req_conditioner.sv
// Scoreboard bench for arb_req_conditioner: a sample-history reference model pushes
// expected outputs each edge, a monitor pops and compares them on the falling edge.
module tb_arb_req_conditioner;

  localparam int N        = 3;
  localparam int DEBOUNCE = 4;
  localparam int TIMEOUT  = 16;
`ifdef ARB_REQ_COND_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam int ST_IDLE = 0;
  localparam int ST_PEND = 1;
  localparam int ST_GNT  = 2;
  localparam int ST_DROP = 3;

  logic         wb_clk_i;
  logic         wb_rst_i;
  logic [N-1:0] req_async;
  logic [N-1:0] gnt;
  logic [N-1:0] req_o;
  logic [N-1:0] timeout_o;

  int checks = 0;
  int errors = 0;

  arb_req_conditioner #(.N(N), .DEBOUNCE(DEBOUNCE), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .req_async_i (req_async),
    .gnt_i       (gnt),
    .req_o       (req_o),
    .timeout_o   (timeout_o)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  // Reference model state
  logic [2*N-1:0] expq [$];
  bit  m_s1 [N];
  bit  m_s2 [N];
  bit  m_deb [N];
  bit  m_tmo [N];
  int  m_st [N];
  int  m_pend_at [N];
  bit  hist [N][$];
  int  cyc = 0;
  int  m_ns;
  bit  m_flip;
  logic [N-1:0] m_req_v, m_tmo_v;

  // Model: acts on the inputs seen at each rising edge
  initial begin
    forever begin
      @(posedge wb_clk_i);
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (wb_rst_i) begin
          m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_deb[i] = 1'b0; m_tmo[i] = 1'b0;
          m_st[i] = ST_IDLE;
          hist[i].delete();
        end else begin
          m_ns = m_st[i];
          if (m_st[i] == ST_IDLE) begin
            if (m_deb[i]) begin m_ns = ST_PEND; m_pend_at[i] = cyc; end
          end else if (m_st[i] == ST_PEND) begin
            if (gnt[i]) m_ns = ST_GNT;
            else if (TMO_EN && (cyc - m_pend_at[i] == TIMEOUT)) begin
              m_ns = ST_DROP; m_tmo[i] = 1'b1;
            end else if (!m_deb[i]) m_ns = ST_IDLE;
          end else begin
            if (!m_deb[i]) m_ns = ST_IDLE;
          end
          // accept a new level once the last DEBOUNCE synchronized samples all disagree
          hist[i].push_back(m_s2[i]);
          if (hist[i].size() > DEBOUNCE) void'(hist[i].pop_front());
          if (hist[i].size() == DEBOUNCE) begin
            m_flip = 1'b1;
            foreach (hist[i][k]) if (hist[i][k] == m_deb[i]) m_flip = 1'b0;
            if (m_flip) m_deb[i] = ~m_deb[i];
          end
          m_s2[i] = m_s1[i];
          m_s1[i] = req_async[i];
          m_st[i] = m_ns;
        end
        m_req_v[i] = (m_st[i] == ST_PEND) || (m_st[i] == ST_GNT);
        m_tmo_v[i] = m_tmo[i];
      end
      expq.push_back({m_req_v, m_tmo_v});
    end
  end

  // Monitor: compares the DUT outputs against the oldest expected entry
  initial begin
    logic [2*N-1:0] e;
    forever begin
      @(negedge wb_clk_i);
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL sb_empty at cycle %0d: no expected entry", cyc);
      end else begin
        e = expq.pop_front();
        if ({req_o, timeout_o} !== e) begin
          errors++;
          $display("FAIL outputs cycle=%0d req_o=%b timeout_o=%b expected req_o=%b timeout_o=%b",
                   cyc, req_o, timeout_o, e[2*N-1:N], e[N-1:0]);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge wb_clk_i);
  endtask

  int first_edge;
  int hold [N];

  initial begin
    wb_rst_i = 1'b1; req_async = 3'b111; gnt = 3'b000;
    cycles(2);
    wb_rst_i = 1'b0; req_async = 3'b000;
    cycles(10);

    // Glitch rejection: 3-cycle pulse dropped
    req_async[0] = 1'b1; cycles(3); req_async[0] = 1'b0; cycles(12);

    // 4-cycle pulse passes; measure assertion latency in edges
    req_async[0] = 1'b1;
    first_edge = -1;
    for (int e = 0; e < 12; e++) begin
      @(posedge wb_clk_i); #1;
      if (first_edge < 0 && req_o[0]) first_edge = e;
      @(negedge wb_clk_i);
      if (e == 3) req_async[0] = 1'b0;
    end
    checks++;
    if (first_edge != DEBOUNCE + 2) begin
      errors++;
      $display("FAIL assert_latency edge=%0d expected=%0d", first_edge, DEBOUNCE + 2);
    end
    cycles(12);

    // Grant and release on ch1
    req_async[1] = 1'b1; cycles(8);
    gnt[1] = 1'b1; cycles(1); gnt[1] = 1'b0; cycles(5);
    req_async[1] = 1'b0; cycles(10);

    // Withdraw on ch2, grant on ch0
    req_async = 3'b101; cycles(8);
    req_async[2] = 1'b0; cycles(2);
    gnt[0] = 1'b1; cycles(1); gnt[0] = 1'b0; cycles(10);
    req_async = 3'b000; cycles(10);

    // Long wait in PEND, then re-request and grant
    req_async[1] = 1'b1; cycles(40);
    req_async[1] = 1'b0; cycles(10);
    req_async[1] = 1'b1; cycles(10);
    gnt[1] = 1'b1; cycles(1); gnt[1] = 1'b0; cycles(3);
    req_async[1] = 1'b0; cycles(10);

    // Reset while ch0 is granted, input still high
    req_async[0] = 1'b1; cycles(8);
    gnt[0] = 1'b1; cycles(1); gnt[0] = 1'b0; cycles(3);
    wb_rst_i = 1'b1; cycles(1); wb_rst_i = 1'b0; cycles(10);
    req_async[0] = 1'b0; cycles(10);

    // Random phase: random hold lengths, sparse grants, rare resets
    for (int i = 0; i < N; i++) hold[i] = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        hold[i]--;
        if (hold[i] == 0) begin
          req_async[i] = ~req_async[i];
          hold[i] = $urandom_range(1, 12);
        end
      end
      gnt = N'($urandom & $urandom & $urandom);
      wb_rst_i = ($urandom_range(0, 299) == 0);
      cycles(1);
    end
    wb_rst_i = 1'b0; req_async = 3'b000; gnt = 3'b000;
    cycles(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
